multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter ALU_SEL_W, default 4, width of alu_select (SHALL be at least 4).
REQ-002 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 opcode  in  6  instr[31:26]; funct  in  6  instr[5:0]; both are sampled from the IR and are valid from DECODE onward.
REQ-006 zero  in  1  ALU zero flag, valid in the BRANCH state.
REQ-007 mem_ready  in  1  memory acknowledge for the current mem_req.
REQ-008 mem_req  out  1  memory request; mem_we  out  1  write request; i_or_d  out  1  address source (0 = PC, 1 = ALUOut).
REQ-009 ir_write, pc_write, reg_write, reg_dest, mem_to_reg, sign_ext, link  out  1 each  datapath enables.
REQ-010 pc_src  out  2  PC source (0 = ALU, 1 = branch target, 2 = jump target, 3 = rs).
REQ-011 alu_src_a  out  1; alu_src_b  out  2 (0 = rt, 1 = const 4, 2 = imm, 3 = imm<<2).
REQ-012 alu_select  out  ALU_SEL_W; load_sel  out  4; store_sel  out  2.
REQ-013 instr_count  out  CNT_W  retired-instruction count; illegal_instr  out  1  trap flag.

Function
REQ-014 The FSM SHALL use these states: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, EXEC, WB_ALU, BRANCH, JUMP, TRAP.
REQ-015 FETCH: mem_req = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 1, alu_select = ADD. The state holds until mem_ready; on mem_ready, ir_write and pc_write pulse for one cycle and the FSM goes to DECODE.
REQ-016 DECODE (1 cycle): alu_src_b = 3, sign_ext = 1 (branch target precompute).
- Loads lbu/lhu/ll/lui/lw and stores sb/sh/sw go to MEM_ADDR.
- R-type, addi/addiu/andi/ori/slti/sltiu go to EXEC.
- beq/bne go to BRANCH.
- j/jal/jr go to JUMP.
- Any other opcode/funct is illegal.
REQ-017 MEM_ADDR: alu_src_a = 1, alu_src_b = 2, sign_ext = 1, ADD. The FSM then goes to MEM_RD (load) or MEM_WR (store).
REQ-018 MEM_RD/MEM_WR: mem_req = 1, i_or_d = 1, mem_we = 1 only in MEM_WR, load_sel/store_sel per opcode. The state holds until mem_ready; then MEM_RD goes to WB_MEM and MEM_WR goes to FETCH.
REQ-019 WB_MEM: reg_write = 1, mem_to_reg = 1, reg_dest = 0; then FETCH.
REQ-020 EXEC: alu_src_a = 1, alu_select per funct/opcode, alu_src_b = 0 (R-type) or 2 (immediate). sign_ext = 1 for addi/addiu/slti/sltiu and 0 for andi/ori. Next state is WB_ALU.
REQ-021 WB_ALU: reg_write = 1, reg_dest = 1 for R-type and 0 otherwise; then FETCH.
REQ-022 BRANCH: alu_select = SUB, pc_src = 1. pc_write = zero for beq and ~zero for bne. Next state is FETCH.
REQ-023 JUMP: pc_write = 1, pc_src = 2 (j/jal) or 3 (jr). For jal, link = reg_write = 1. Next state is FETCH.
REQ-024 load_sel and store_sel SHALL be all-ones in every state other than REQ-018.
- load_sel: lbu 0, lhu 1, ll 2, lui 3, lw 4.
- store_sel: sb 0, sh 1, sw 2.
REQ-025 instr_count SHALL increment by 1 on the final-state exit to FETCH of every legal instruction. It wraps modulo 2^CNT_W.
REQ-026 Any output not named in a state SHALL be 0 in that state.
REQ-027 mem_ready outside FETCH/MEM_RD/MEM_WR SHALL be ignored.
REQ-028 mem_req SHALL stay high until the mem_ready cycle inclusive.

Reset
REQ-029 rst_n low SHALL immediately force FETCH, instr_count = 0, illegal_instr = 0, and all outputs to their FETCH values with pc_write/ir_write = 0.
REQ-030 Reset mid-access SHALL abandon the access without any register or PC write.

Configuration
REQ-031 Macro MCU_ILLEGAL_TRAP_EN defined: an illegal instruction in DECODE goes to TRAP, which sets illegal_instr = 1 and holds with every enable at 0 until reset.
REQ-032 MCU_ILLEGAL_TRAP_EN undefined: an illegal instruction goes DECODE -> FETCH as a NOP, instr_count is not incremented, the TRAP state is absent, and illegal_instr is tied to 0.

Structure
REQ-033 Package mcu_pkg SHALL hold:
- the state enum;
- the ALU select codes (add 0, addu 1, and 2, nor 3, or 4, slt 5, sltu 6, sll 7, srl 8, sub 9, subu 10, jump 11);
- the load/store select codes;
- the opcode/funct constants.
REQ-034 The combinational opcode/funct classifier SHALL be the sub-module mcu_decode. It outputs the instruction class, alu_select, sign_ext, load_sel, store_sel and legal.

Verification
REQ-035 lw (opcode 100011) with mem_ready delayed 2 cycles in FETCH and MEM_RD -> states FETCH x3, DECODE, MEM_ADDR, MEM_RD x3, WB_MEM; load_sel = 4 in MEM_RD; instr_count 0 -> 1.
REQ-036 beq with zero = 1 -> pc_write = 1 and pc_src = 1 in BRANCH. bne with zero = 1 -> pc_write = 0.
REQ-037 R-type funct 001000 (jr) -> JUMP with pc_src = 3 and reg_write = 0. jal -> link = 1, reg_write = 1, pc_src = 2.
REQ-038 opcode 111111 -> with MCU_ILLEGAL_TRAP_EN: TRAP, illegal_instr = 1, held 10 cycles. Without it: FETCH next, instr_count unchanged.
REQ-039 rst_n low during MEM_WR with mem_ready = 0 -> FETCH immediately; mem_we = 0 and instr_count = 0.
REQ-040 CNT_W = 4, 16 addi instructions -> instr_count wraps to 0.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared constants for the multicycle control unit: FSM states, ALU/load/store codes, opcodes.
// The optional illegal-instruction trap is enabled by defining MCU_ILLEGAL_TRAP_EN.
package mcu_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_FETCH    = 4'd0;
    localparam state_t ST_DECODE   = 4'd1;
    localparam state_t ST_MEM_ADDR = 4'd2;
    localparam state_t ST_MEM_RD   = 4'd3;
    localparam state_t ST_MEM_WR   = 4'd4;
    localparam state_t ST_WB_MEM   = 4'd5;
    localparam state_t ST_EXEC     = 4'd6;
    localparam state_t ST_WB_ALU   = 4'd7;
    localparam state_t ST_BRANCH   = 4'd8;
    localparam state_t ST_JUMP     = 4'd9;
    localparam state_t ST_TRAP     = 4'd10;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_LOAD,
        CLS_STORE,
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_BRANCH,
        CLS_JUMP
    } instr_class_e;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_ADDU = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_NOR  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SUB  = 4'd9;
    localparam logic [3:0] ALU_SUBU = 4'd10;
    localparam logic [3:0] ALU_JUMP = 4'd11;

    localparam logic [3:0] LS_LBU  = 4'd0;
    localparam logic [3:0] LS_LHU  = 4'd1;
    localparam logic [3:0] LS_LL   = 4'd2;
    localparam logic [3:0] LS_LUI  = 4'd3;
    localparam logic [3:0] LS_LW   = 4'd4;
    localparam logic [3:0] LS_NONE = 4'hF;

    localparam logic [1:0] SS_SB   = 2'd0;
    localparam logic [1:0] SS_SH   = 2'd1;
    localparam logic [1:0] SS_SW   = 2'd2;
    localparam logic [1:0] SS_NONE = 2'd3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LL    = 6'b110000;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

endpackage

// File: rtl/mcu_decode.sv
// Combinational opcode/funct classifier: instruction class, ALU select, immediate extension
// and memory access size. Unrecognised encodings come out as CLS_ILLEGAL with legal_o low.
module mcu_decode
    import mcu_pkg::*;
(
    input  logic [5:0]   opcode_i,
    input  logic [5:0]   funct_i,
    output instr_class_e class_o,
    output logic [3:0]   alu_sel_o,
    output logic         sign_ext_o,
    output logic [3:0]   load_sel_o,
    output logic [1:0]   store_sel_o,
    output logic         legal_o
);

    always_comb begin
        class_o     = CLS_ILLEGAL;
        alu_sel_o   = ALU_ADD;
        sign_ext_o  = 1'b0;
        load_sel_o  = LS_NONE;
        store_sel_o = SS_NONE;
        case (opcode_i)
            OP_RTYPE: begin
                class_o = CLS_ALU_R;
                case (funct_i)
                    F_ADD:   alu_sel_o = ALU_ADD;
                    F_ADDU:  alu_sel_o = ALU_ADDU;
                    F_SUB:   alu_sel_o = ALU_SUB;
                    F_SUBU:  alu_sel_o = ALU_SUBU;
                    F_AND:   alu_sel_o = ALU_AND;
                    F_OR:    alu_sel_o = ALU_OR;
                    F_NOR:   alu_sel_o = ALU_NOR;
                    F_SLT:   alu_sel_o = ALU_SLT;
                    F_SLTU:  alu_sel_o = ALU_SLTU;
                    F_SLL:   alu_sel_o = ALU_SLL;
                    F_SRL:   alu_sel_o = ALU_SRL;
                    F_JR: begin
                        class_o   = CLS_JUMP;
                        alu_sel_o = ALU_JUMP;
                    end
                    default: class_o = CLS_ILLEGAL;
                endcase
            end
            OP_J, OP_JAL: begin
                class_o   = CLS_JUMP;
                alu_sel_o = ALU_JUMP;
            end
            OP_BEQ, OP_BNE: begin
                class_o   = CLS_BRANCH;
                alu_sel_o = ALU_SUB;
            end
            OP_ADDI:  begin class_o = CLS_ALU_I; alu_sel_o = ALU_ADD;  sign_ext_o = 1'b1; end
            OP_ADDIU: begin class_o = CLS_ALU_I; alu_sel_o = ALU_ADDU; sign_ext_o = 1'b1; end
            OP_SLTI:  begin class_o = CLS_ALU_I; alu_sel_o = ALU_SLT;  sign_ext_o = 1'b1; end
            OP_SLTIU: begin class_o = CLS_ALU_I; alu_sel_o = ALU_SLTU; sign_ext_o = 1'b1; end
            OP_ANDI:  begin class_o = CLS_ALU_I; alu_sel_o = ALU_AND; end
            OP_ORI:   begin class_o = CLS_ALU_I; alu_sel_o = ALU_OR;  end
            OP_LBU:   begin class_o = CLS_LOAD;  load_sel_o = LS_LBU; end
            OP_LHU:   begin class_o = CLS_LOAD;  load_sel_o = LS_LHU; end
            OP_LL:    begin class_o = CLS_LOAD;  load_sel_o = LS_LL;  end
            OP_LUI:   begin class_o = CLS_LOAD;  load_sel_o = LS_LUI; end
            OP_LW:    begin class_o = CLS_LOAD;  load_sel_o = LS_LW;  end
            OP_SB:    begin class_o = CLS_STORE; store_sel_o = SS_SB; end
            OP_SH:    begin class_o = CLS_STORE; store_sel_o = SS_SH; end
            OP_SW:    begin class_o = CLS_STORE; store_sel_o = SS_SW; end
            default:  class_o = CLS_ILLEGAL;
        endcase
    end

    assign legal_o = (class_o != CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style control FSM with a retired-instruction counter.
// Define MCU_ILLEGAL_TRAP_EN to trap on illegal instructions instead of treating them as NOPs.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int ALU_SEL_W = 4,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 i_or_d,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic                 reg_dest,
    output logic                 mem_to_reg,
    output logic                 sign_ext,
    output logic                 link,
    output logic [1:0]           pc_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALU_SEL_W-1:0] alu_select,
    output logic [3:0]           load_sel,
    output logic [1:0]           store_sel,
    output logic [CNT_W-1:0]     instr_count,
    output logic                 illegal_instr
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;
    logic [3:0]       alu_sel;

    instr_class_e dec_class;
    logic [3:0]   dec_alu_sel;
    logic         dec_sign_ext;
    logic [3:0]   dec_load_sel;
    logic [1:0]   dec_store_sel;
    logic         dec_legal;

    mcu_decode u_decode (
        .opcode_i    (opcode),
        .funct_i     (funct),
        .class_o     (dec_class),
        .alu_sel_o   (dec_alu_sel),
        .sign_ext_o  (dec_sign_ext),
        .load_sel_o  (dec_load_sel),
        .store_sel_o (dec_store_sel),
        .legal_o     (dec_legal)
    );

    // retire marks the last cycle of a legal instruction, just before returning to FETCH
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (!dec_legal) begin
`ifdef MCU_ILLEGAL_TRAP_EN
                    state_d = ST_TRAP;
`else
                    state_d = ST_FETCH;
`endif
                end else begin
                    case (dec_class)
                        CLS_LOAD, CLS_STORE:  state_d = ST_MEM_ADDR;
                        CLS_ALU_R, CLS_ALU_I: state_d = ST_EXEC;
                        CLS_BRANCH:           state_d = ST_BRANCH;
                        default:              state_d = ST_JUMP;
                    endcase
                end
            end
            ST_MEM_ADDR: state_d = (dec_class == CLS_STORE) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   if (mem_ready) state_d = ST_WB_MEM;
            ST_MEM_WR: begin
                if (mem_ready) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_EXEC:     state_d = ST_WB_ALU;
            ST_WB_MEM, ST_WB_ALU, ST_BRANCH, ST_JUMP: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
`ifdef MCU_ILLEGAL_TRAP_EN
            ST_TRAP:     state_d = ST_TRAP;
`endif
            default:     state_d = ST_FETCH;
        endcase
        count_d = retire ? count_q + CNT_W'(1) : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // ir_write/pc_write are gated by rst_n so a reset mid-fetch never commits the word
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dest   = 1'b0;
        mem_to_reg = 1'b0;
        sign_ext   = 1'b0;
        link       = 1'b0;
        pc_src     = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_sel    = ALU_ADD;
        load_sel   = LS_NONE;
        store_sel  = SS_NONE;
        case (state_q)
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready & rst_n;
                pc_write  = mem_ready & rst_n;
            end
            ST_DECODE: begin
                alu_src_b = 2'd3;
                sign_ext  = 1'b1;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                sign_ext  = 1'b1;
            end
            ST_MEM_RD, ST_MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = (state_q == ST_MEM_WR);
                i_or_d    = 1'b1;
                load_sel  = dec_load_sel;
                store_sel = dec_store_sel;
            end
            ST_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = (dec_class == CLS_ALU_R) ? 2'd0 : 2'd2;
                alu_sel   = dec_alu_sel;
                sign_ext  = dec_sign_ext;
            end
            ST_WB_ALU: begin
                reg_write = 1'b1;
                reg_dest  = (dec_class == CLS_ALU_R);
            end
            ST_BRANCH: begin
                alu_sel  = ALU_SUB;
                pc_src   = 2'd1;
                pc_write = (opcode == OP_BNE) ? ~zero : zero;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_src    = (opcode == OP_RTYPE) ? 2'd3 : 2'd2;
                link      = (opcode == OP_JAL);
                reg_write = (opcode == OP_JAL);
            end
            default: ;
        endcase
    end

    assign alu_select  = ALU_SEL_W'(alu_sel);
    assign instr_count = count_q;

`ifdef MCU_ILLEGAL_TRAP_EN
    assign illegal_instr = (state_q == ST_TRAP);
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed testbench for multicycle_control_unit; each task walks one instruction
// sequence cycle by cycle against hand-derived control vectors.
module tb_multicycle_control_unit;

    // {illegal, mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, reg_dest,
    //  mem_to_reg, sign_ext, link, pc_src, alu_src_a, alu_src_b, alu_select, load_sel, store_sel}
    typedef logic [25:0] vec_t;

    localparam vec_t V_FW     = {11'b01000000000, 2'd0, 1'b0, 2'd1, 4'd0, 4'hF, 2'd3};
    localparam vec_t V_FR     = {11'b01001100000, 2'd0, 1'b0, 2'd1, 4'd0, 4'hF, 2'd3};
    localparam vec_t V_DEC    = {11'b00000000010, 2'd0, 1'b0, 2'd3, 4'd0, 4'hF, 2'd3};
    localparam vec_t V_MADDR  = {11'b00000000010, 2'd0, 1'b1, 2'd2, 4'd0, 4'hF, 2'd3};
    localparam vec_t V_MRD_LW = {11'b01010000000, 2'd0, 1'b0, 2'd0, 4'd0, 4'd4, 2'd3};
    localparam vec_t V_MWR_SW = {11'b01110000000, 2'd0, 1'b0, 2'd0, 4'd0, 4'hF, 2'd2};
    localparam vec_t V_WBM    = {11'b00000010100, 2'd0, 1'b0, 2'd0, 4'd0, 4'hF, 2'd3};
    localparam vec_t V_EX_ADD = {11'b00000000000, 2'd0, 1'b1, 2'd0, 4'd0, 4'hF, 2'd3};
    localparam vec_t V_EX_SUB = {11'b00000000000, 2'd0, 1'b1, 2'd0, 4'd9, 4'hF, 2'd3};
    localparam vec_t V_EX_ANDI= {11'b00000000000, 2'd0, 1'b1, 2'd2, 4'd2, 4'hF, 2'd3};
    localparam vec_t V_EX_ADDI= {11'b00000000010, 2'd0, 1'b1, 2'd2, 4'd0, 4'hF, 2'd3};
    localparam vec_t V_WB_R   = {11'b00000011000, 2'd0, 1'b0, 2'd0, 4'd0, 4'hF, 2'd3};
    localparam vec_t V_WB_I   = {11'b00000010000, 2'd0, 1'b0, 2'd0, 4'd0, 4'hF, 2'd3};
    localparam vec_t V_BR_T   = {11'b00000100000, 2'd1, 1'b0, 2'd0, 4'd9, 4'hF, 2'd3};
    localparam vec_t V_BR_N   = {11'b00000000000, 2'd1, 1'b0, 2'd0, 4'd9, 4'hF, 2'd3};
    localparam vec_t V_J_JR   = {11'b00000100000, 2'd3, 1'b0, 2'd0, 4'd0, 4'hF, 2'd3};
    localparam vec_t V_J_JAL  = {11'b00000110001, 2'd2, 1'b0, 2'd0, 4'd0, 4'hF, 2'd3};
    localparam vec_t V_TRAP   = {11'b10000000000, 2'd0, 1'b0, 2'd0, 4'd0, 4'hF, 2'd3};

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;

    logic        mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, reg_dest;
    logic        mem_to_reg, sign_ext, link, alu_src_a, illegal_instr;
    logic [1:0]  pc_src, alu_src_b, store_sel;
    logic [3:0]  alu_select, load_sel;
    logic [31:0] instr_count;

    logic        mem_req_4, mem_we_4, i_or_d_4, ir_write_4, pc_write_4, reg_write_4, reg_dest_4;
    logic        mem_to_reg_4, sign_ext_4, link_4, alu_src_a_4, illegal_instr_4;
    logic [1:0]  pc_src_4, alu_src_b_4, store_sel_4;
    logic [3:0]  alu_select_4, load_sel_4;
    logic [3:0]  instr_count_4;

    int checks   = 0;
    int failures = 0;
    int expCount = 0;

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .reg_dest(reg_dest),
        .mem_to_reg(mem_to_reg), .sign_ext(sign_ext), .link(link), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_select(alu_select),
        .load_sel(load_sel), .store_sel(store_sel), .instr_count(instr_count),
        .illegal_instr(illegal_instr)
    );

    multicycle_control_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req_4), .mem_we(mem_we_4), .i_or_d(i_or_d_4),
        .ir_write(ir_write_4), .pc_write(pc_write_4), .reg_write(reg_write_4),
        .reg_dest(reg_dest_4), .mem_to_reg(mem_to_reg_4), .sign_ext(sign_ext_4),
        .link(link_4), .pc_src(pc_src_4), .alu_src_a(alu_src_a_4), .alu_src_b(alu_src_b_4),
        .alu_select(alu_select_4), .load_sel(load_sel_4), .store_sel(store_sel_4),
        .instr_count(instr_count_4), .illegal_instr(illegal_instr_4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t obs();
        return {illegal_instr, mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, reg_dest,
                mem_to_reg, sign_ext, link, pc_src, alu_src_a, alu_src_b, alu_select,
                load_sel, store_sel};
    endfunction

    // drive one cycle's inputs, sample at the falling edge, then step past the rising edge
    task automatic cycle(input logic rdy, input logic z, output vec_t o,
                         output logic [31:0] c, output logic [3:0] c4);
        mem_ready = rdy;
        zero      = z;
        @(negedge clk);
        o  = obs();
        c  = instr_count;
        c4 = instr_count_4;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expCount = 0;
    endtask

    task automatic test_reset();
        vec_t o;
        #2;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #1;
        o = obs();
        checks++;
        if (o !== V_FW) begin
            failures++;
            $display("[TB] FAIL reset_async_outputs: got %h expected %h", o, V_FW);
        end
        @(posedge clk);
        #1;
        o = obs();
        checks++;
        if (o !== V_FW) begin
            failures++;
            $display("[TB] FAIL reset_held_outputs: got %h expected %h", o, V_FW);
        end
        checks++;
        if (instr_count !== 32'd0 || instr_count_4 !== 4'd0) begin
            failures++;
            $display("[TB] FAIL reset_count: got %0d/%0d expected 0/0", instr_count, instr_count_4);
        end
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lw();
        vec_t e [9] = '{V_FW, V_FW, V_FR, V_DEC, V_MADDR, V_MRD_LW, V_MRD_LW, V_MRD_LW, V_WBM};
        logic r [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vec_t o;
        logic [31:0] c;
        logic [3:0] c4;
        opcode = 6'b100011;
        funct  = 6'b000000;
        for (int i = 0; i < 9; i++) begin
            cycle(r[i], 1'b0, o, c, c4);
            checks++;
            if (o !== e[i]) begin
                failures++;
                $display("[TB] FAIL lw_cycle%0d: got %h expected %h", i, o, e[i]);
            end
        end
        expCount = 1;
        cycle(1'b0, 1'b0, o, c, c4);
        checks++;
        if (c !== 32'(expCount) || o !== V_FW) begin
            failures++;
            $display("[TB] FAIL lw_retire: got count %0d vec %h expected %0d %h", c, o, expCount, V_FW);
        end
    endtask

    task automatic test_branch();
        vec_t e [6] = '{V_FR, V_DEC, V_BR_T, V_FR, V_DEC, V_BR_N};
        vec_t o;
        logic [31:0] c;
        logic [3:0] c4;
        for (int i = 0; i < 6; i++) begin
            opcode = (i < 3) ? 6'b000100 : 6'b000101;
            cycle(i == 0 || i == 3, 1'b1, o, c, c4);
            checks++;
            if (o !== e[i]) begin
                failures++;
                $display("[TB] FAIL branch_cycle%0d: got %h expected %h", i, o, e[i]);
            end
        end
        expCount += 2;
        cycle(1'b0, 1'b0, o, c, c4);
        checks++;
        if (c !== 32'(expCount)) begin
            failures++;
            $display("[TB] FAIL branch_count: got %0d expected %0d", c, expCount);
        end
    endtask

    task automatic test_jump();
        vec_t e [6] = '{V_FR, V_DEC, V_J_JR, V_FR, V_DEC, V_J_JAL};
        vec_t o;
        logic [31:0] c;
        logic [3:0] c4;
        for (int i = 0; i < 6; i++) begin
            opcode = (i < 3) ? 6'b000000 : 6'b000011;
            funct  = 6'b001000;
            cycle(i == 0 || i == 3, 1'b0, o, c, c4);
            checks++;
            if (o !== e[i]) begin
                failures++;
                $display("[TB] FAIL jump_cycle%0d: got %h expected %h", i, o, e[i]);
            end
        end
        expCount += 2;
        cycle(1'b0, 1'b0, o, c, c4);
        checks++;
        if (c !== 32'(expCount)) begin
            failures++;
            $display("[TB] FAIL jump_count: got %0d expected %0d", c, expCount);
        end
    endtask

    task automatic test_alu();
        vec_t e [12] = '{V_FR, V_DEC, V_EX_ADD, V_WB_R, V_FR, V_DEC, V_EX_SUB, V_WB_R,
                         V_FR, V_DEC, V_EX_ANDI, V_WB_I};
        logic [5:0] ops [3] = '{6'b000000, 6'b000000, 6'b001100};
        logic [5:0] fns [3] = '{6'b100000, 6'b100010, 6'b000000};
        vec_t o;
        logic [31:0] c;
        logic [3:0] c4;
        for (int i = 0; i < 12; i++) begin
            opcode = ops[i / 4];
            funct  = fns[i / 4];
            cycle((i % 4) == 0, 1'b0, o, c, c4);
            checks++;
            if (o !== e[i]) begin
                failures++;
                $display("[TB] FAIL alu_cycle%0d: got %h expected %h", i, o, e[i]);
            end
        end
        expCount += 3;
        cycle(1'b0, 1'b0, o, c, c4);
        checks++;
        if (c !== 32'(expCount)) begin
            failures++;
            $display("[TB] FAIL alu_count: got %0d expected %0d", c, expCount);
        end
    endtask

    task automatic test_illegal();
        vec_t o;
        logic [31:0] c;
        logic [3:0] c4;
        opcode = 6'b111111;
        funct  = 6'b000000;
        cycle(1'b1, 1'b0, o, c, c4);
        checks++;
        if (o !== V_FR) begin
            failures++;
            $display("[TB] FAIL illegal_fetch: got %h expected %h", o, V_FR);
        end
        cycle(1'b0, 1'b0, o, c, c4);
        checks++;
        if (o !== V_DEC) begin
            failures++;
            $display("[TB] FAIL illegal_decode: got %h expected %h", o, V_DEC);
        end
`ifdef MCU_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            cycle(i[0], 1'b0, o, c, c4);
            checks++;
            if (o !== V_TRAP || c !== 32'(expCount)) begin
                failures++;
                $display("[TB] FAIL trap_hold%0d: got %h count %0d expected %h count %0d",
                         i, o, c, V_TRAP, expCount);
            end
        end
        reset_dut();
`else
        cycle(1'b0, 1'b0, o, c, c4);
        checks++;
        if (o !== V_FW || c !== 32'(expCount)) begin
            failures++;
            $display("[TB] FAIL illegal_nop: got %h count %0d expected %h count %0d",
                     o, c, V_FW, expCount);
        end
`endif
    endtask

    task automatic test_store_reset();
        vec_t e [5] = '{V_FR, V_DEC, V_MADDR, V_MWR_SW, V_MWR_SW};
        logic r [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vec_t o;
        logic [31:0] c;
        logic [3:0] c4;
        opcode = 6'b101011;
        funct  = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            cycle(r[i], 1'b0, o, c, c4);
            checks++;
            if (o !== e[i]) begin
                failures++;
                $display("[TB] FAIL sw_cycle%0d: got %h expected %h", i, o, e[i]);
            end
        end
        checks++;
        if (c !== 32'(expCount)) begin
            failures++;
            $display("[TB] FAIL sw_count_before_reset: got %0d expected %0d", c, expCount);
        end
        mem_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        o = obs();
        checks++;
        if (o !== V_FW || instr_count !== 32'd0) begin
            failures++;
            $display("[TB] FAIL sw_abort_reset: got %h count %0d expected %h count 0",
                     o, instr_count, V_FW);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expCount = 0;
    endtask

    task automatic test_wrap();
        vec_t e [4] = '{V_FR, V_DEC, V_EX_ADDI, V_WB_I};
        vec_t o;
        logic [31:0] c;
        logic [3:0] c4;
        reset_dut();
        opcode = 6'b001000;
        funct  = 6'b000000;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 4; i++) begin
                cycle(i == 0, 1'b0, o, c, c4);
                checks++;
                if (o !== e[i]) begin
                    failures++;
                    $display("[TB] FAIL addi%0d_cycle%0d: got %h expected %h", k, i, o, e[i]);
                end
            end
        end
        cycle(1'b0, 1'b0, o, c, c4);
        checks++;
        if (c !== 32'd16 || c4 !== 4'd0) begin
            failures++;
            $display("[TB] FAIL count_wrap: got %0d/%0d expected 16/0", c, c4);
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        opcode    = 6'b000000;
        funct     = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_branch();
        test_jump();
        test_alu();
        test_illegal();
        test_store_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
